// File: rtl/aes_key_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_pkg
// Brief    : Shared constants, round constants and types for the AES-128
//            key-schedule controller.
// Revision : 1.0
// ============================================================================
package aes_key_pkg;

  localparam int NR   = 10;
  localparam int KW   = 128;
  localparam int IDXW = 4;

  // Round constants, MSB-aligned in a 32-bit word (byte 0 is rcon, rest zero).
  localparam logic [0:31] RCON [1:NR] = '{
    32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000, 32'h10000000,
    32'h20000000, 32'h40000000, 32'h80000000, 32'h1b000000, 32'h36000000
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_e;

  typedef logic [0:NR][0:KW-1] rk_array_t;

endpackage
`default_nettype wire

// File: rtl/aes_key_sched_ctrl_key_gen.sv
`default_nettype none
// ============================================================================
// Module   : key_gen
// Brief    : Combinational AES-128 key-expansion round step (one round key
//            from the previous one). S-box computed as GF(2^8) inverse + affine.
// Revision : 1.0
// ============================================================================
module key_gen (
  input  logic [0:127] inKey,
  input  logic [0:31]  rcon,
  output logic [0:127] outKey
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] p;
    logic [7:0] s;
    t = gf_mul(a, a);
    p = t;
    for (int i = 0; i < 6; i++) begin
      t = gf_mul(t, t);
      p = gf_mul(p, t);
    end
    s = p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
    return s;
  endfunction

  logic [0:31] w0, w1, w2, w3;
  logic [0:31] rot_w, sub_w, temp_w;
  logic [0:31] o0, o1, o2, o3;

  assign w0 = inKey[0:31];
  assign w1 = inKey[32:63];
  assign w2 = inKey[64:95];
  assign w3 = inKey[96:127];

  assign rot_w  = {w3[8:31], w3[0:7]};
  assign sub_w  = {sbox(rot_w[0:7]), sbox(rot_w[8:15]), sbox(rot_w[16:23]), sbox(rot_w[24:31])};
  assign temp_w = sub_w ^ rcon;

  assign o0 = w0 ^ temp_w;
  assign o1 = w1 ^ o0;
  assign o2 = w2 ^ o1;
  assign o3 = w3 ^ o2;

  assign outKey = {o0, o1, o2, o3};

endmodule
`default_nettype wire

// File: rtl/aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_sched_ctrl
// Brief    : Iterative AES-128 key schedule with an 11-entry round-key file
//            and indexed read port. AES_KEY_CACHE_EN skips re-expanding a
//            key identical to the one already held in READY.
// Revision : 1.0
// ============================================================================
module aes_key_sched_ctrl
  import aes_key_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [0:127] key_in,
  input  logic         key_valid,
  output logic         key_ack,
  output logic         busy,
  output logic         keys_ready,
  input  logic         rk_req,
  input  logic [3:0]   rk_idx,
  output logic         rk_valid,
  output logic [0:127] rk_out,
  output logic         rk_err
);

  state_e          state_q, state_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  rk_array_t       rk_q, rk_d;
  logic [0:KW-1]   rk_out_q, rk_out_d;
  logic            rk_valid_q, rk_valid_d;
  logic            rk_err_q, rk_err_d;

  logic            accept;
  logic            cache_hit;
  logic [0:KW-1]   kg_in;
  logic [0:31]     kg_rcon;
  logic [0:KW-1]   kg_out;
  logic [0:KW-1]   rd_key;

  assign key_ack    = (state_q == ST_IDLE) || (state_q == ST_READY);
  assign busy       = (state_q == ST_EXPAND);
  assign keys_ready = (state_q == ST_READY);
  assign rk_valid   = rk_valid_q;
  assign rk_out     = rk_out_q;
  assign rk_err     = rk_err_q;

  assign accept = key_valid && key_ack;

`ifdef AES_KEY_CACHE_EN
  assign cache_hit = (state_q == ST_READY) && (key_in == rk_q[0]);
`else
  assign cache_hit = 1'b0;
`endif

  // Selects are written as compare loops so no index can run off the file.
  always_comb begin
    kg_in   = rk_q[0];
    kg_rcon = RCON[1];
    for (int i = 1; i <= NR; i++) begin
      if (cnt_q == IDXW'(i)) begin
        kg_in   = rk_q[i-1];
        kg_rcon = RCON[i];
      end
    end
  end

  always_comb begin
    rd_key = rk_q[0];
    for (int i = 0; i <= NR; i++) begin
      if (rk_idx == IDXW'(i)) rd_key = rk_q[i];
    end
  end

  key_gen u_key_gen (
    .inKey  (kg_in),
    .rcon   (kg_rcon),
    .outKey (kg_out)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rk_d       = rk_q;
    rk_out_d   = rk_out_q;
    rk_valid_d = 1'b0;
    rk_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rk_d[0] = key_in;
          cnt_d   = IDXW'(1);
          state_d = ST_EXPAND;
        end
      end

      ST_EXPAND: begin
        for (int i = 1; i <= NR; i++) begin
          if (cnt_q == IDXW'(i)) rk_d[i] = kg_out;
        end
        if (cnt_q == IDXW'(NR)) begin
          cnt_d   = '0;
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q + IDXW'(1);
        end
      end

      ST_READY: begin
        // A key load always takes priority; the coincident read is dropped.
        if (accept) begin
          if (!cache_hit) begin
            rk_d[0] = key_in;
            cnt_d   = IDXW'(1);
            state_d = ST_EXPAND;
          end
        end else if (rk_req) begin
          if (rk_idx <= IDXW'(NR)) begin
            rk_out_d   = rd_key;
            rk_valid_d = 1'b1;
          end else begin
            rk_err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rk_q       <= '0;
      rk_out_q   <= '0;
      rk_valid_q <= 1'b0;
      rk_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rk_q       <= rk_d;
      rk_out_q   <= rk_out_d;
      rk_valid_q <= rk_valid_d;
      rk_err_q   <= rk_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_sched_ctrl
// Brief    : Self-checking bench for aes_key_sched_ctrl using FIPS-197 vectors.
// Revision : 1.0
// ============================================================================
module tb_aes_key_sched_ctrl;

  localparam int NR = 10;

  localparam logic [0:127] K1       = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] K1_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [0:127] K2       = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] K2_RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic         clk = 1'b0;
  logic         reset;
  logic [0:127] key_in;
  logic         key_valid;
  logic         key_ack;
  logic         busy;
  logic         keys_ready;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic [0:127] rk_out;
  logic         rk_err;

  int total = 0;
  int bad   = 0;
  logic [0:127] exp_q [$];

  aes_key_sched_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ack    (key_ack),
    .busy       (busy),
    .keys_ready (keys_ready),
    .rk_req     (rk_req),
    .rk_idx     (rk_idx),
    .rk_valid   (rk_valid),
    .rk_out     (rk_out),
    .rk_err     (rk_err)
  );

  always #5 clk = ~clk;

  // Stimulus only: accept a key and count edges until keys_ready is seen.
  task automatic load_key(input logic [0:127] k, output int lat);
    @(negedge clk);
    key_in    = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    lat = 0;
    while (!keys_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Stimulus only: one-cycle read request, expected key goes to the scoreboard.
  task automatic issue_read(input logic [3:0] idx, input logic [0:127] exp);
    @(negedge clk);
    rk_req = 1'b1;
    rk_idx = idx;
    exp_q.push_back(exp);
    @(negedge clk);
    rk_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({key_ack, busy, keys_ready, rk_valid, rk_err} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=10000", {key_ack, busy, keys_ready, rk_valid, rk_err});
    end
    total++;
    if (rk_out !== 128'h0) begin
      bad++;
      $display("FAIL reset_rk_out got=%h want=0", rk_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_fips_key();
    int lat;
    logic [0:127] e;
    load_key(K1, lat);
    total++;
    if (lat !== 10) begin
      bad++;
      $display("FAIL k1_latency got=%0d want=10", lat);
    end
    issue_read(4'd10, K1_RK10);
    total++;
    if (rk_valid !== 1'b1 || exp_q.size() == 0) begin
      bad++;
      $display("FAIL k1_read_valid got=%b want=1", rk_valid);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (rk_out !== e) begin
        bad++;
        $display("FAIL k1_rk10 got=%h want=%h", rk_out, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int vrun;
    logic [0:127] e;
    load_key(K2, lat);
    total++;
    if (lat !== 10) begin
      bad++;
      $display("FAIL k2_latency got=%0d want=10", lat);
    end
    vrun = 0;
    for (int i = 0; i <= NR + 1; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++;
        if (rk_valid !== 1'b1 || exp_q.size() == 0) begin
          bad++;
          $display("FAIL b2b_valid step=%0d got=%b want=1", i, rk_valid);
        end else begin
          vrun++;
          e = exp_q.pop_front();
          total++;
          if (rk_out !== e) begin
            bad++;
            $display("FAIL b2b_rk idx=%0d got=%h want=%h", NR + 1 - i, rk_out, e);
          end
        end
      end
      if (i <= NR) begin
        rk_req = 1'b1;
        rk_idx = 4'(NR - i);
        exp_q.push_back(K2_RK[NR - i]);
      end else begin
        rk_req = 1'b0;
      end
    end
    @(negedge clk);
    total++;
    if (rk_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_valid_drop got=%b want=0", rk_valid);
    end
    total++;
    if (vrun !== 11) begin
      bad++;
      $display("FAIL b2b_run got=%0d want=11", vrun);
    end
  endtask

  task automatic test_bad_index();
    logic [3:0] idxs [0:1];
    idxs[0] = 4'd11;
    idxs[1] = 4'd15;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      rk_req = 1'b1;
      rk_idx = idxs[j];
      @(negedge clk);
      rk_req = 1'b0;
      total++;
      if (rk_err !== 1'b1 || rk_valid !== 1'b0) begin
        bad++;
        $display("FAIL bad_idx_flags idx=%0d got err=%b valid=%b want err=1 valid=0", idxs[j], rk_err, rk_valid);
      end
      total++;
      if (rk_out !== K2_RK[0]) begin
        bad++;
        $display("FAIL bad_idx_hold idx=%0d got=%h want=%h", idxs[j], rk_out, K2_RK[0]);
      end
      @(negedge clk);
      total++;
      if (rk_err !== 1'b0) begin
        bad++;
        $display("FAIL bad_idx_pulse idx=%0d got=%b want=0", idxs[j], rk_err);
      end
    end
  endtask

  task automatic test_reset_mid_expand();
    int lat;
    logic [0:127] e;
    @(negedge clk);
    key_in    = K1;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({key_ack, busy, keys_ready, rk_valid} !== 4'b1000) begin
      bad++;
      $display("FAIL midrst_flags got=%b want=1000", {key_ack, busy, keys_ready, rk_valid});
    end
    total++;
    if (rk_out !== 128'h0) begin
      bad++;
      $display("FAIL midrst_rk_out got=%h want=0", rk_out);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || keys_ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst_idle got busy=%b ready=%b want 0 0", busy, keys_ready);
    end
    load_key(K2, lat);
    total++;
    if (lat !== 10) begin
      bad++;
      $display("FAIL midrst_latency got=%0d want=10", lat);
    end
    issue_read(4'd10, K2_RK[10]);
    total++;
    if (rk_valid !== 1'b1 || exp_q.size() == 0) begin
      bad++;
      $display("FAIL midrst_read_valid got=%b want=1", rk_valid);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (rk_out !== e) begin
        bad++;
        $display("FAIL midrst_rk10 got=%h want=%h", rk_out, e);
      end
    end
  endtask

  task automatic test_load_read_collision();
    logic [0:127] e;
    @(negedge clk);
    key_in    = K1;
    key_valid = 1'b1;
    rk_req    = 1'b1;
    rk_idx    = 4'd3;
    @(negedge clk);
    total++;
    if ({rk_valid, rk_err, busy, key_ack} !== 4'b0010) begin
      bad++;
      $display("FAIL coll_first got=%b want=0010", {rk_valid, rk_err, busy, key_ack});
    end
    // A different key and reads held through EXPAND must all be ignored.
    key_in = K2;
    rk_idx = 4'd2;
    for (int k = 1; k <= NR; k++) begin
      @(negedge clk);
      if (k < NR) begin
        total++;
        if ({rk_valid, rk_err, busy, key_ack} !== 4'b0010) begin
          bad++;
          $display("FAIL coll_expand cyc=%0d got=%b want=0010", k, {rk_valid, rk_err, busy, key_ack});
        end
      end else begin
        key_valid = 1'b0;
        rk_req    = 1'b0;
        total++;
        if ({rk_valid, rk_err, busy, keys_ready} !== 4'b0001) begin
          bad++;
          $display("FAIL coll_done got=%b want=0001", {rk_valid, rk_err, busy, keys_ready});
        end
      end
    end
    issue_read(4'd10, K1_RK10);
    total++;
    if (rk_valid !== 1'b1 || exp_q.size() == 0) begin
      bad++;
      $display("FAIL coll_read_valid got=%b want=1", rk_valid);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (rk_out !== e) begin
        bad++;
        $display("FAIL coll_rk10 got=%h want=%h", rk_out, e);
      end
    end
  endtask

  task automatic test_resend_same_key();
    int n;
    logic [0:127] e;
    @(negedge clk);
    key_in    = K1;
    key_valid = 1'b1;
    rk_req    = 1'b1;
    rk_idx    = 4'd0;
    @(negedge clk);
    key_valid = 1'b0;
    rk_req    = 1'b0;
    total++;
    if (rk_valid !== 1'b0) begin
      bad++;
      $display("FAIL resend_read_drop got=%b want=0", rk_valid);
    end
`ifdef AES_KEY_CACHE_EN
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (busy !== 1'b0 || keys_ready !== 1'b1) n++;
      @(negedge clk);
    end
    total++;
    if (n !== 0) begin
      bad++;
      $display("FAIL resend_cache_hit cycles_not_ready got=%0d want=0", n);
    end
`else
    n = 0;
    while (busy && n < 30) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n !== 10) begin
      bad++;
      $display("FAIL resend_busy_cycles got=%0d want=10", n);
    end
    total++;
    if (keys_ready !== 1'b1) begin
      bad++;
      $display("FAIL resend_ready got=%b want=1", keys_ready);
    end
`endif
    issue_read(4'd10, K1_RK10);
    total++;
    if (rk_valid !== 1'b1 || exp_q.size() == 0) begin
      bad++;
      $display("FAIL resend_read_valid got=%b want=1", rk_valid);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (rk_out !== e) begin
        bad++;
        $display("FAIL resend_rk10 got=%h want=%h", rk_out, e);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    key_in    = '0;
    key_valid = 1'b0;
    rk_req    = 1'b0;
    rk_idx    = 4'd0;
    test_reset();
    test_fips_key();
    test_back_to_back();
    test_bad_index();
    test_reset_mid_expand();
    test_load_read_collision();
    test_resend_same_key();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Iterative AES-128 key-schedule controller.
- Accepts a cipher key over a valid/ack handshake.
- Runs one shared `key_gen` round-step instance once per cycle for 10 cycles, and stores all 11 round keys in a register file.
- Serves any round key by index to the decryptor round datapath, typically in reverse order (10 down to 0).
- Replaces the fully unrolled 10-stage key expansion with one round-step instance.

Parameters:
- NR, 10, number of AES rounds; the round-key file holds NR+1 entries.
- KW, 128, key and round-key width in bits; vectors are indexed [0:KW-1], with bit 0 as the MSB.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- key_in  in  [0:127]  cipher key; sampled on the acceptance edge.
- key_valid  in  1  key_in is valid.
- key_ack  out  1  controller can accept a key; high in IDLE and READY.
- busy  out  1  expansion in progress; high in EXPAND.
- keys_ready  out  1  all 11 round keys are valid.
- rk_req  in  1  round-key read request.
- rk_idx  in  [3:0]  requested round index, 0..10.
- rk_valid  out  1  rk_out is valid this cycle; single-cycle pulse.
- rk_out  out  [0:127]  requested round key.
- rk_err  out  1  one-cycle pulse when a request has rk_idx > 10.

Behaviour:
- Reset (synchronous, any state, including mid-EXPAND):
  - State goes to IDLE; round counter goes to 0.
  - All 11 round-key registers go to 0.
  - Outputs: rk_out=0, rk_valid=0, rk_err=0, keys_ready=0, busy=0, key_ack=1 after the edge.
- Key acceptance: a key is accepted on an edge where key_valid && key_ack.
  - rk[0] <= key_in; cnt <= 1; state goes to EXPAND.
  - keys_ready and key_ack drop on that same edge.
- EXPAND: each edge, rk[cnt] <= key_gen(rk[cnt-1], RCON[cnt]), then cnt increments.
  - On the edge that writes rk[10]: state goes to READY, keys_ready=1, key_ack=1.
  - Latency: keys_ready rises exactly 10 edges after the acceptance edge.
  - key_valid is ignored while in EXPAND (key_ack=0).
  - rk_req is ignored in EXPAND: rk_valid=0, rk_err=0.
- READY: rk_req=1 with rk_idx<=10 gives rk_out <= rk[rk_idx] and rk_valid=1 on the next edge (1-cycle latency).
  - Back-to-back requests give one key per cycle.
  - rk_idx>10: rk_err=1 and rk_valid=0 for one cycle; rk_out holds its previous value.
- Simultaneous key_valid and rk_req in READY: the key load wins and the read is dropped (rk_valid=0, rk_err=0). The new expansion starts as above.
- IDLE: rk_req is ignored.
- rk_out holds its last value whenever rk_valid=0.
- The RCON index wraps nowhere: cnt never exceeds 10, and cnt resets to 0 in READY and IDLE.
- State encoding: IDLE, EXPAND, READY.
  - IDLE to EXPAND on acceptance.
  - EXPAND to READY at cnt==10.
  - READY to EXPAND on acceptance.
  - Any state to IDLE on reset only.

Optional Feature:
- Macro: AES_KEY_CACHE_EN.
- Defined: in READY, an accepted key equal to rk[0] is a cache hit.
  - No expansion occurs; state stays READY and keys_ready stays 1.
  - A read requested on that same edge is dropped.
- Undefined: every accepted key re-expands, even if it is identical.
- The port list is identical in both builds.

Decomposition:
- Package `aes_key_pkg`:
  - KW, NR.
  - RCON[1..10] as 32-bit MSB-aligned constants: 01,02,04,08,10,20,40,80,1b,36 followed by 000000.
  - The state enum typedef.
  - The round-key array typedef [0:NR][0:KW-1].
- Sub-module: a single instance of the existing `key_gen` (inKey, rcon, outKey) as the combinational round step. No other sub-modules.

Test Plan:
- Reset, then load key 000102030405060708090a0b0c0d0e0f:
  - keys_ready rises 10 cycles after acceptance.
  - Reading rk_idx=10 gives 13111d7fe3944a17f307a78b4d2b30c5 one cycle later.
- Load 2b7e151628aed2a6abf7158809cf4f3c, then read indices 10..0 back-to-back:
  - rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6, rk[1]=a0fafe1788542cb123a339392a6c7605, rk[0]=key.
  - rk_valid is high for 11 consecutive cycles.
- In READY, request rk_idx=11 and rk_idx=15: rk_err pulses each time, rk_valid=0, rk_out is unchanged.
- Assert reset at cycle 5 of EXPAND:
  - The next cycle shows IDLE, keys_ready=0, rk_out=0.
  - Reloading a key gives correct rk[10].
- In READY, assert key_valid and rk_req on the same edge with a new key: no rk_valid, busy=1, and the new rk[10] is correct after 10 cycles. During EXPAND, key_ack=0 and rk_req gives no response.
- With AES_KEY_CACHE_EN, re-send the identical key in READY: busy stays 0 and keys_ready stays 1. Without the macro, busy is high for 10 cycles.
